// File: rtl/kpad_pkg.sv
// Shared types and constants for the 4x4 keypad scan controller.
package kpad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } kpad_state_e;

    // Row drive pattern out of reset (row 0 active).
    localparam logic [3:0] ROW_IDLE = 4'b1110;
    // Column pattern with no key pressed (pull-ups win).
    localparam logic [3:0] COL_NONE = 4'b1111;

    // Key codes, entry {row, col} at nibble row*4+col.
    // row0: 1 2 3 A / row1: 4 5 6 B / row2: 7 8 9 C / row3: 0 F E D
    localparam logic [63:0] KEY_LUT = 64'hDEF0_C987_B654_A321;

    function automatic logic [3:0] key_lookup(input logic [1:0] r, input logic [1:0] c);
        logic [5:0] bitpos;
        bitpos = {r, c, 2'b00};
        return KEY_LUT[bitpos +: 4];
    endfunction

    // Index of the lowest-numbered low column; only meaningful when some column is low.
    function automatic logic [1:0] first_low(input logic [3:0] c);
        logic [1:0] sel;
        sel = 2'd3;
        for (int i = 3; i >= 0; i--) begin
            if (!c[i]) sel = 2'(i);
        end
        return sel;
    endfunction

endpackage

// File: rtl/kpad_stable_cnt.sv
// Counts consecutive cycles that cond is high; done flags the N-th such cycle.
// The count saturates at N-1 and clears when cond drops or clr is asserted.
module kpad_stable_cnt #(
    parameter int N = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic cond,
    output logic done
);

    localparam int W = (N > 1) ? $clog2(N) : 1;
    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] cnt_q, cnt_d;

    // Next count: restart on clear or broken condition, hold at the terminal value.
    always_comb begin
        cnt_d = cnt_q;
        if (clr || !cond) begin
            cnt_d = '0;
        end else if (cnt_q != LAST) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign done = cond && (cnt_q == LAST);

endmodule

// File: rtl/kpad_scan_ctrl.sv
// 4x4 keypad scanner: row drive, column sync, press/release debounce, and a
// valid/ready key output. Define KPAD_REPEAT_EN to enable auto-repeat while held.
module kpad_scan_ctrl
    import kpad_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 5000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] col,
    output logic [3:0] row,
    output logic       key_valid,
    input  logic       key_ready,
    output logic [3:0] key_code,
    output logic       key_down,
    output logic       key_overflow
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);

    logic [3:0]  col_s1_q, col_s2_q;
    logic [3:0]  col_sync;
    kpad_state_e state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [1:0]  cidx_q, cidx_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [3:0]  row_q, row_d;
    logic        key_valid_q, key_valid_d;
    logic [3:0]  key_code_q, key_code_d;
    logic        ovf_q, ovf_d;
    logic        emit;
    logic        rep_done;

    logic press_cond, press_clr, press_done;
    logic rel_cond, rel_clr, rel_done;

    // Two-flop synchronizer for the asynchronous column inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_s1_q <= COL_NONE;
            col_s2_q <= COL_NONE;
        end else begin
            col_s1_q <= col;
            col_s2_q <= col_s1_q;
        end
    end

    assign col_sync = col_s2_q;

    // Press confirmation: the captured column must stay low throughout.
    assign press_cond = (state_q == DEBOUNCE) && !col_sync[cidx_q];
    assign press_clr  = (state_q != DEBOUNCE);

    kpad_stable_cnt #(.N(DEBOUNCE_CYC)) u_press_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (press_clr),
        .cond  (press_cond),
        .done  (press_done)
    );

    // Release confirmation: every column high; any low column restarts it.
    assign rel_cond = (state_q == HELD) && (col_sync == COL_NONE);
    assign rel_clr  = (state_q != HELD);

    kpad_stable_cnt #(.N(DEBOUNCE_CYC)) u_rel_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (rel_clr),
        .cond  (rel_cond),
        .done  (rel_done)
    );

`ifdef KPAD_REPEAT_EN
    logic rep_started_q, rep_started_d;
    logic rep_first_done, rep_rate_done;

    // First repeat after REPEAT_DELAY held cycles, then one every REPEAT_RATE.
    kpad_stable_cnt #(.N(REPEAT_DELAY)) u_rep_first_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state_q != HELD),
        .cond  ((state_q == HELD) && !rep_started_q),
        .done  (rep_first_done)
    );

    kpad_stable_cnt #(.N(REPEAT_RATE)) u_rep_rate_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   ((state_q != HELD) || rep_rate_done),
        .cond  ((state_q == HELD) && rep_started_q),
        .done  (rep_rate_done)
    );

    assign rep_started_d = (state_q == HELD) && (rep_started_q || rep_first_done);
    assign rep_done      = (state_q == HELD) && (rep_first_done || rep_rate_done);

    // Tracks whether the initial repeat delay has elapsed for the current hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rep_started_q <= 1'b0;
        else        rep_started_q <= rep_started_d;
    end
`else
    assign rep_done = 1'b0;

    // Auto-repeat is absent in this build; REPEAT_* elaborate to nothing.
    if (!((REPEAT_DELAY > 0) && (REPEAT_RATE > 0))) begin : g_repeat_cfg_unused
    end
`endif

    // Scan/debounce/hold sequencing plus the key emit and handshake rules.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cidx_d      = cidx_q;
        dwell_d     = '0;
        key_valid_d = key_valid_q;
        key_code_d  = key_code_q;
        ovf_d       = 1'b0;
        emit        = 1'b0;

        if (key_valid_q && key_ready) key_valid_d = 1'b0;

        case (state_q)
            SCAN: begin
                if (dwell_q == DWELL_LAST) begin
                    if (col_sync == COL_NONE) begin
                        idx_d = idx_q + 2'd1;
                    end else begin
                        cidx_d  = first_low(col_sync);
                        state_d = DEBOUNCE;
                    end
                end else begin
                    dwell_d = dwell_q + DW'(1);
                end
            end
            DEBOUNCE: begin
                if (col_sync[cidx_q]) begin
                    state_d = SCAN;
                    idx_d   = idx_q + 2'd1;
                end else if (press_done) begin
                    state_d = HELD;
                    emit    = 1'b1;
                end
            end
            HELD: begin
                if (rel_done) begin
                    state_d = SCAN;
                    idx_d   = idx_q + 2'd1;
                end
                if (rep_done) emit = 1'b1;
            end
            default: state_d = SCAN;
        endcase

        // A new key loads if the slot is empty or being consumed this cycle.
        if (emit) begin
            if (!key_valid_q || key_ready) begin
                key_code_d  = key_lookup(idx_q, cidx_q);
                key_valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end

        row_d = ~(4'b0001 << idx_d);
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SCAN;
            idx_q       <= 2'd0;
            cidx_q      <= 2'd0;
            dwell_q     <= '0;
            row_q       <= ROW_IDLE;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'h0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cidx_q      <= cidx_d;
            dwell_q     <= dwell_d;
            row_q       <= row_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            ovf_q       <= ovf_d;
        end
    end

    assign row          = row_q;
    assign key_valid    = key_valid_q;
    assign key_code     = key_code_q;
    assign key_down     = (state_q == HELD);
    assign key_overflow = ovf_q;

endmodule

// File: tb/tb_kpad_scan_ctrl.sv
// Directed bench for kpad_scan_ctrl with a simple keypad model on the pins.
module tb_kpad_scan_ctrl;

    logic       clk;
    logic       rst_n;
    logic [3:0] col;
    logic [3:0] row;
    logic       key_valid;
    logic       key_ready;
    logic [3:0] key_code;
    logic       key_down;
    logic       key_overflow;

    // Keypad model: one pressed switch (kp_r, kp_c) or a forced column pattern.
    logic       kp_on;
    logic [1:0] kp_r, kp_c;
    logic       man_on;
    logic [3:0] man_col;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0] r;
        logic [1:0] c;
        logic [3:0] code;
    } vec_t;

    vec_t vecs[16];

    kpad_scan_ctrl #(
        .SCAN_DIV     (4),
        .DEBOUNCE_CYC (8),
        .REPEAT_DELAY (16),
        .REPEAT_RATE  (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .col          (col),
        .row          (row),
        .key_valid    (key_valid),
        .key_ready    (key_ready),
        .key_code     (key_code),
        .key_down     (key_down),
        .key_overflow (key_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        col = 4'b1111;
        if (man_on) col = man_col;
        else if (kp_on && !row[kp_r]) col = ~(4'b0001 << kp_c);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_valid(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (key_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_down(input logic v, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            tick();
            if (key_down == v) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Holds reset for two cycles; releases it 1 time unit after a rising edge.
    task automatic do_reset();
        rst_n   = 1'b0;
        kp_on   = 1'b0;
        man_on  = 1'b0;
        man_col = 4'b1111;
        key_ready = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        bit seen;
        logic [3:0] exp_rows [4];

        vecs[0]  = '{2'd0, 2'd0, 4'h1};
        vecs[1]  = '{2'd0, 2'd1, 4'h2};
        vecs[2]  = '{2'd0, 2'd2, 4'h3};
        vecs[3]  = '{2'd0, 2'd3, 4'hA};
        vecs[4]  = '{2'd1, 2'd0, 4'h4};
        vecs[5]  = '{2'd1, 2'd1, 4'h5};
        vecs[6]  = '{2'd1, 2'd2, 4'h6};
        vecs[7]  = '{2'd1, 2'd3, 4'hB};
        vecs[8]  = '{2'd2, 2'd0, 4'h7};
        vecs[9]  = '{2'd2, 2'd1, 4'h8};
        vecs[10] = '{2'd2, 2'd2, 4'h9};
        vecs[11] = '{2'd2, 2'd3, 4'hC};
        vecs[12] = '{2'd3, 2'd0, 4'h0};
        vecs[13] = '{2'd3, 2'd1, 4'hF};
        vecs[14] = '{2'd3, 2'd2, 4'hE};
        vecs[15] = '{2'd3, 2'd3, 4'hD};

        exp_rows[0] = 4'b1101;
        exp_rows[1] = 4'b1011;
        exp_rows[2] = 4'b0111;
        exp_rows[3] = 4'b1110;

        kp_r = 2'd0;
        kp_c = 2'd0;

        // Reset values while rst_n is low, then idle row stepping.
        rst_n   = 1'b0;
        kp_on   = 1'b0;
        man_on  = 1'b0;
        man_col = 4'b1111;
        key_ready = 1'b1;
        repeat (2) tick();
        check("rst_row", row, 4'b1110);
        check("rst_valid", key_valid, 1'b0);
        check("rst_code", key_code, 4'h0);
        check("rst_down", key_down, 1'b0);
        check("rst_ovf", key_overflow, 1'b0);
        rst_n = 1'b1;
        repeat (3) tick();
        check("idle_row0_dwell", row, 4'b1110);
        tick();
        check("idle_row_step0", row, exp_rows[0]);
        for (int k = 1; k < 4; k++) begin
            repeat (4) tick();
            check($sformatf("idle_row_step%0d", k), row, exp_rows[k]);
        end
        check("idle_valid", key_valid, 1'b0);

        // Every key of the matrix, one press each, consumer always ready.
        for (int v = 0; v < 16; v++) begin
            kp_r  = vecs[v].r;
            kp_c  = vecs[v].c;
            kp_on = 1'b1;
            wait_valid(100, ok);
            check($sformatf("lut_valid_seen_%0d", v), ok, 1'b1);
            check($sformatf("lut_code_%0d", v), key_code, vecs[v].code);
            check($sformatf("lut_down_%0d", v), key_down, 1'b1);
            tick();
            check($sformatf("lut_valid_drop_%0d", v), key_valid, 1'b0);
            kp_on = 1'b0;
            wait_down(1'b0, 60, ok);
            check($sformatf("lut_release_%0d", v), ok, 1'b1);
        end

        // Key 8 release timing: two synchronizer cycles plus 8 stable cycles.
        do_reset();
        kp_r = 2'd2; kp_c = 2'd1; kp_on = 1'b1;
        wait_valid(100, ok);
        check("k8_seen", ok, 1'b1);
        check("k8_code", key_code, 4'h8);
        check("k8_row_frozen", row, 4'b1011);
        tick();
        check("k8_valid_one_cycle", key_valid, 1'b0);
        kp_on = 1'b0;
        repeat (9) tick();
        check("k8_down_before_release", key_down, 1'b1);
        tick();
        check("k8_down_after_release", key_down, 1'b0);
        check("k8_next_row", row, 4'b0111);

        // Bounce on row 0: low for 3 cycles only, no key, scan moves to row 1.
        rst_n   = 1'b0;
        kp_on   = 1'b0;
        man_on  = 1'b1;
        man_col = 4'b1110;
        key_ready = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        man_col = 4'b1111;
        repeat (2) tick();
        check("bounce_row_frozen", row, 4'b1110);
        check("bounce_no_down", key_down, 1'b0);
        tick();
        check("bounce_next_row", row, 4'b1101);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (key_valid || key_down) seen = 1'b1;
        end
        check("bounce_no_key", seen, 1'b0);
        man_on = 1'b0;

        // Consumer stalled: press 5 then 9; 9 is dropped with one overflow pulse.
        do_reset();
        key_ready = 1'b0;
        kp_r = 2'd1; kp_c = 2'd1; kp_on = 1'b1;
        wait_valid(100, ok);
        check("ovf_k5_seen", ok, 1'b1);
        check("ovf_k5_code", key_code, 4'h5);
        kp_on = 1'b0;
        wait_down(1'b0, 60, ok);
        check("ovf_k5_release", ok, 1'b1);
        kp_r = 2'd2; kp_c = 2'd2; kp_on = 1'b1;
        wait_down(1'b1, 100, ok);
        check("ovf_k9_held", ok, 1'b1);
        check("ovf_pulse", key_overflow, 1'b1);
        check("ovf_code_kept", key_code, 4'h5);
        check("ovf_valid_kept", key_valid, 1'b1);
        tick();
        check("ovf_pulse_end", key_overflow, 1'b0);
        key_ready = 1'b1;
        tick();
        check("ovf_valid_drop", key_valid, 1'b0);
        kp_on = 1'b0;
        wait_down(1'b0, 60, ok);
        check("ovf_k9_release", ok, 1'b1);

        // Ready rises exactly on the confirmation cycle of a new key.
        do_reset();
        key_ready = 1'b0;
        kp_r = 2'd0; kp_c = 2'd0; kp_on = 1'b1;
        wait_valid(100, ok);
        check("rdy_k1_seen", ok, 1'b1);
        check("rdy_k1_code", key_code, 4'h1);
        kp_on = 1'b0;
        wait_down(1'b0, 60, ok);
        check("rdy_k1_release", ok, 1'b1);
        kp_r = 2'd1; kp_c = 2'd2; kp_on = 1'b1;
        repeat (11) tick();
        check("rdy_pre_down", key_down, 1'b0);
        check("rdy_pre_code", key_code, 4'h1);
        check("rdy_pre_valid", key_valid, 1'b1);
        key_ready = 1'b1;
        tick();
        check("rdy_new_code", key_code, 4'h6);
        check("rdy_new_valid", key_valid, 1'b1);
        check("rdy_no_ovf", key_overflow, 1'b0);
        check("rdy_new_down", key_down, 1'b1);
        tick();
        check("rdy_consumed", key_valid, 1'b0);
        kp_on = 1'b0;
        wait_down(1'b0, 60, ok);
        check("rdy_k6_release", ok, 1'b1);

        // Reset while a key is held, key kept pressed through reset release.
        do_reset();
        kp_r = 2'd2; kp_c = 2'd1; kp_on = 1'b1;
        wait_down(1'b1, 100, ok);
        check("mid_held", ok, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_row", row, 4'b1110);
        check("mid_rst_valid", key_valid, 1'b0);
        check("mid_rst_code", key_code, 4'h0);
        check("mid_rst_down", key_down, 1'b0);
        check("mid_rst_ovf", key_overflow, 1'b0);
        tick();
        rst_n = 1'b1;
        wait_valid(100, ok);
        check("mid_reemit_seen", ok, 1'b1);
        check("mid_reemit_code", key_code, 4'h8);
        kp_on = 1'b0;
        wait_down(1'b0, 60, ok);
        check("mid_release", ok, 1'b1);

`ifdef KPAD_REPEAT_EN
        // Auto-repeat: emissions 16 and 24 cycles after confirmation.
        do_reset();
        kp_r = 2'd0; kp_c = 2'd2; kp_on = 1'b1;
        wait_valid(100, ok);
        check("rep_seen", ok, 1'b1);
        for (int i = 1; i <= 26; i++) begin
            tick();
            check($sformatf("rep_valid_t%0d", i), key_valid, (i == 16 || i == 24) ? 1'b1 : 1'b0);
        end
        check("rep_code", key_code, 4'h3);
        kp_on = 1'b0;
        wait_down(1'b0, 60, ok);
        check("rep_release", ok, 1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
